// File: rtl/ahb5_pkg.sv
// rtl/ahb5_pkg.sv - shared AHB5 constants, responder FSM states and byte-strobe helper
package ahb5_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb5_state_e;

  // Byte-lane enables of a 32-bit word for a transfer of the given size
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << a;
      HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: s = 4'b1111;
      default:    s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ahb5_excl_monitor.sv
// rtl/ahb5_excl_monitor.sv - two-entry exclusive reservation table indexed by manager ID bit 0
module ahb5_excl_monitor
  import ahb5_pkg::*;
#(
  parameter int W_IDX = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set,
  input  logic             i_set_id,
  input  logic [W_IDX-1:0] i_set_idx,
  input  logic             i_clr,
  input  logic [W_IDX-1:0] i_clr_idx,
  input  logic             i_chk_id,
  input  logic [W_IDX-1:0] i_chk_idx,
  output logic             o_chk_ok
);

  logic             r_valid [2];
  logic [W_IDX-1:0] r_idx   [2];

  // Committed writes drop every matching reservation; a same-edge exclusive read is newer and wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_valid[i] <= 1'b0;
        r_idx[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i_clr && r_valid[i] && (r_idx[i] == i_clr_idx)) r_valid[i] <= 1'b0;
      end
      if (i_set) begin
        r_valid[i_set_id] <= 1'b1;
        r_idx[i_set_id]   <= i_set_idx;
      end
    end
  end

  assign o_chk_ok = r_valid[i_chk_id] && (r_idx[i_chk_id] == i_chk_idx);

endmodule

// File: rtl/ahb5_sram_responder.sv
// rtl/ahb5_sram_responder.sv - AHB5 SRAM subordinate with wait states, ERROR responses, write forwarding; optional AHB5_EXCL_MONITOR_EN
module ahb5_sram_responder
  import ahb5_pkg::*;
#(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic              hready,
  input  logic [W_ADDR-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [3:0]        hprot,
  input  logic [7:0]        hmaster,
  input  logic              hexcl,
  input  logic [W_DATA-1:0] hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              hexokay,
  output logic [W_DATA-1:0] hrdata
);

  localparam int AW = $clog2(DEPTH);

  ahb5_state_e       r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;

  logic              r_dp_valid;
  logic              r_dp_write;
  logic              r_dp_id;
  logic              r_dp_excl;
  logic [AW-1:0]     r_dp_idx;
  logic [3:0]        r_dp_strb;
  logic [W_DATA-1:0] r_rdata;
  logic [W_DATA-1:0] r_mem [DEPTH];

  logic              w_accept, w_illegal, w_acc_ok, w_acc_err;
  logic              w_final, w_wr_allow, w_commit, w_unused_ok;
  logic [AW-1:0]     w_idx;
  logic [3:0]        w_strb;
  logic [W_DATA-1:0] w_wmask, w_wmerged, w_rd_word;

  assign w_accept  = hsel && hready && ((htrans & HTRANS_NSEQ) != HTRANS_IDLE);
  assign w_illegal = (hsize > HSIZE_WORD)
                   || ((hsize == HSIZE_HALF) && haddr[0])
                   || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                   || (|haddr[W_ADDR-1:AW+2]);
  assign w_acc_ok  = w_accept && !w_illegal;
  assign w_acc_err = w_accept && w_illegal;
  assign w_idx     = haddr[AW+1:2];
  assign w_strb    = byte_strobe(hsize, haddr[1:0]);

  // The data phase ends in the first IDLE cycle after a legal accept (after any wait states)
  assign w_final   = (r_state == ST_IDLE) && r_dp_valid;
  assign w_commit  = w_final && r_dp_write && w_wr_allow && !rst;

  // Expand the captured byte strobe into a bit mask for the merge
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < 4; b++) w_wmask[8*b +: 8] = {8{r_dp_strb[b]}};
  end

  assign w_wmerged = (r_mem[r_dp_idx] & ~w_wmask) | (hwdata & w_wmask);
  assign w_rd_word = (w_commit && (r_dp_idx == w_idx)) ? w_wmerged : r_mem[w_idx];

  assign hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign hresp     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
  assign hrdata    = r_rdata;

  // Response FSM state and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: new transfers are taken from IDLE and from the second ERROR cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_acc_err) begin
          w_state_nxt = ST_ERR1;
        end else if (w_acc_ok && (WAIT_STATES > 0)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 3'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_state_nxt = ST_IDLE;
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the address-phase attributes that the data phase needs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_id    <= 1'b0;
      r_dp_excl  <= 1'b0;
      r_dp_idx   <= '0;
      r_dp_strb  <= 4'b0000;
    end else if (w_acc_ok) begin
      r_dp_valid <= 1'b1;
      r_dp_write <= hwrite;
      r_dp_id    <= hmaster[0];
      r_dp_excl  <= hexcl;
      r_dp_idx   <= w_idx;
      r_dp_strb  <= w_strb;
    end else if (w_final) begin
      r_dp_valid <= 1'b0;
    end
  end

  // Read data is fetched at accept and held through wait states; zero once the bus is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_acc_ok && !hwrite) begin
      r_rdata <= w_rd_word;
    end else if (hreadyout) begin
      r_rdata <= '0;
    end
  end

  // Byte-masked SRAM write on the edge closing a write data phase
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_dp_idx] <= w_wmerged;
  end

`ifdef AHB5_EXCL_MONITOR_EN
  logic w_chk_ok;

  ahb5_excl_monitor #(
    .W_IDX (AW)
  ) u_excl (
    .clk       (clk),
    .rst       (rst),
    .i_set     (w_acc_ok && hexcl && !hwrite),
    .i_set_id  (hmaster[0]),
    .i_set_idx (w_idx),
    .i_clr     (w_commit),
    .i_clr_idx (r_dp_idx),
    .i_chk_id  (r_dp_id),
    .i_chk_idx (r_dp_idx),
    .o_chk_ok  (w_chk_ok)
  );

  assign w_wr_allow  = !r_dp_excl || w_chk_ok;
  assign hexokay     = w_final && r_dp_excl && (!r_dp_write || w_chk_ok);
  assign w_unused_ok = ^{hprot, hmaster[7:1]};
`else
  assign w_wr_allow  = 1'b1;
  assign hexokay     = 1'b0;
  assign w_unused_ok = ^{hprot, hmaster[7:1], hexcl, r_dp_id, r_dp_excl};
`endif

endmodule

// File: tb/tb_ahb5_sram_responder.sv
// tb/tb_ahb5_sram_responder.sv - directed self-checking bench for ahb5_sram_responder (0 and 3 wait states)
module tb_ahb5_sram_responder;
  import ahb5_pkg::*;

`ifdef AHB5_EXCL_MONITOR_EN
  localparam bit EXCL = 1'b1;
`else
  localparam bit EXCL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel0 = 1'b0, hsel3 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [3:0]  hprot = '0;
  logic [7:0]  hmaster = '0;
  logic        hexcl = 1'b0;
  logic [31:0] hwdata = '0;

  logic        hreadyout0, hresp0, hexokay0;
  logic [31:0] hrdata0;
  logic        hreadyout3, hresp3, hexokay3;
  logic [31:0] hrdata3;
  logic        hready0, hready3;

  int n_pass = 0;
  int n_total = 0;
  int n;

  assign hready0 = hreadyout0;
  assign hready3 = hreadyout3;

  always #5 clk = ~clk;

  ahb5_sram_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .hsel(hsel0), .hready(hready0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hmaster(hmaster), .hexcl(hexcl),
    .hwdata(hwdata), .hreadyout(hreadyout0), .hresp(hresp0), .hexokay(hexokay0), .hrdata(hrdata0)
  );

  ahb5_sram_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .hsel(hsel3), .hready(hready3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hmaster(hmaster), .hexcl(hexcl),
    .hwdata(hwdata), .hreadyout(hreadyout3), .hresp(hresp3), .hexokay(hexokay3), .hrdata(hrdata3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hexcl = 1'b0;
  endtask

  task automatic addr(input bit d3, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic x, input logic [7:0] m);
    hsel0 = !d3; hsel3 = d3; haddr = a; htrans = HTRANS_NSEQ; hwrite = w;
    hsize = sz; hexcl = x; hmaster = m; hprot = 4'b0011;
  endtask

  task automatic test_reset();
    step();
    n_total++; if (hreadyout0 !== 1'b1) $display("FAIL rst_hreadyout0 got %b exp 1", hreadyout0); else n_pass++;
    n_total++; if (hresp0 !== 1'b0) $display("FAIL rst_hresp0 got %b exp 0", hresp0); else n_pass++;
    n_total++; if (hexokay0 !== 1'b0) $display("FAIL rst_hexokay0 got %b exp 0", hexokay0); else n_pass++;
    n_total++; if (hrdata0 !== 32'h0) $display("FAIL rst_hrdata0 got %h exp 0", hrdata0); else n_pass++;
    n_total++; if (hreadyout3 !== 1'b1) $display("FAIL rst_hreadyout3 got %b exp 1", hreadyout3); else n_pass++;
    n_total++; if (hresp3 !== 1'b0) $display("FAIL rst_hresp3 got %b exp 0", hresp3); else n_pass++;
    n_total++; if (hrdata3 !== 32'h0) $display("FAIL rst_hrdata3 got %h exp 0", hrdata3); else n_pass++;
  endtask

  task automatic test_forward();
    addr(0, 32'h4, 1, HSIZE_WORD, 0, 8'h00);
    step();
    hwdata = 32'hDEADBEEF;
    addr(0, 32'h4, 0, HSIZE_WORD, 0, 8'h00);
    n_total++; if (hreadyout0 !== 1'b1) $display("FAIL fwd_wr_ready got %b exp 1", hreadyout0); else n_pass++;
    step();
    idle_bus();
    n_total++; if (hreadyout0 !== 1'b1) $display("FAIL fwd_rd_ready got %b exp 1", hreadyout0); else n_pass++;
    n_total++; if (hrdata0 !== 32'hDEADBEEF) $display("FAIL fwd_data got %h exp DEADBEEF", hrdata0); else n_pass++;
    step();
    n_total++; if (hrdata0 !== 32'h0) $display("FAIL fwd_idle_rdata got %h exp 0", hrdata0); else n_pass++;
  endtask

  task automatic test_byte_merge();
    addr(0, 32'h4, 1, HSIZE_WORD, 0, 8'h00);
    step();
    hwdata = 32'h11223344;
    addr(0, 32'h5, 1, HSIZE_BYTE, 0, 8'h00);
    step();
    hwdata = 32'h5555AA55;
    addr(0, 32'h4, 0, HSIZE_WORD, 0, 8'h00);
    step();
    n_total++; if (hrdata0 !== 32'h1122AA44) $display("FAIL byte_merge got %h exp 1122AA44", hrdata0); else n_pass++;
    addr(0, 32'h6, 1, HSIZE_HALF, 0, 8'h00);
    step();
    hwdata = 32'hBEEF1234;
    idle_bus();
    step();
    addr(0, 32'h4, 0, HSIZE_WORD, 0, 8'h00);
    step();
    idle_bus();
    n_total++; if (hrdata0 !== 32'hBEEFAA44) $display("FAIL half_merge got %h exp BEEFAA44", hrdata0); else n_pass++;
    step();
  endtask

  task automatic test_wait_states();
    addr(1, 32'h40, 1, HSIZE_WORD, 0, 8'h00);
    hwdata = 32'hCAFEF00D;
    step();
    addr(1, 32'h2000, 1, HSIZE_WORD, 0, 8'h00);
    n = 0;
    while (!hreadyout3 && n < 20) begin
      n++;
      step();
      idle_bus();
    end
    n_total++; if (n !== 3) $display("FAIL ws_write_cycles got %0d exp 3", n); else n_pass++;
    n_total++; if (hresp3 !== 1'b0) $display("FAIL ws_ignored_htrans hresp got %b exp 0", hresp3); else n_pass++;
    step();
    addr(1, 32'h40, 0, HSIZE_WORD, 0, 8'h00);
    step();
    idle_bus();
    n = 0;
    while (!hreadyout3 && n < 20) begin
      n++;
      step();
    end
    n_total++; if (n !== 3) $display("FAIL ws_read_cycles got %0d exp 3", n); else n_pass++;
    n_total++; if (hrdata3 !== 32'hCAFEF00D) $display("FAIL ws_read_data got %h exp CAFEF00D", hrdata3); else n_pass++;
    step();
    n_total++; if (hrdata3 !== 32'h0) $display("FAIL ws_idle_rdata got %h exp 0", hrdata3); else n_pass++;
  endtask

  task automatic test_error();
    addr(0, 32'h0, 1, HSIZE_WORD, 0, 8'h00);
    step();
    hwdata = 32'hA5A5A5A5;
    addr(0, 32'h2, 1, HSIZE_WORD, 0, 8'h00);
    step();
    hwdata = 32'hFFFFFFFF;
    n_total++; if ({hreadyout0, hresp0} !== 2'b01) $display("FAIL err_misalign_c1 got %b exp 01", {hreadyout0, hresp0}); else n_pass++;
    addr(0, 32'h1000, 1, HSIZE_WORD, 0, 8'h00);
    step();
    n_total++; if ({hreadyout0, hresp0} !== 2'b11) $display("FAIL err_misalign_c2 got %b exp 11", {hreadyout0, hresp0}); else n_pass++;
    step();
    n_total++; if ({hreadyout0, hresp0} !== 2'b01) $display("FAIL err_oob_c1 got %b exp 01", {hreadyout0, hresp0}); else n_pass++;
    addr(0, 32'h0, 1, 3'd3, 0, 8'h00);
    step();
    n_total++; if ({hreadyout0, hresp0} !== 2'b11) $display("FAIL err_oob_c2 got %b exp 11", {hreadyout0, hresp0}); else n_pass++;
    step();
    n_total++; if ({hreadyout0, hresp0} !== 2'b01) $display("FAIL err_size_c1 got %b exp 01", {hreadyout0, hresp0}); else n_pass++;
    addr(0, 32'h0, 0, HSIZE_WORD, 0, 8'h00);
    step();
    n_total++; if ({hreadyout0, hresp0} !== 2'b11) $display("FAIL err_size_c2 got %b exp 11", {hreadyout0, hresp0}); else n_pass++;
    step();
    idle_bus();
    n_total++; if ({hreadyout0, hresp0} !== 2'b10) $display("FAIL err_after_rd_resp got %b exp 10", {hreadyout0, hresp0}); else n_pass++;
    n_total++; if (hrdata0 !== 32'hA5A5A5A5) $display("FAIL err_mem_unchanged got %h exp A5A5A5A5", hrdata0); else n_pass++;
    step();
  endtask

  task automatic test_exclusive();
    addr(0, 32'h10, 1, HSIZE_WORD, 0, 8'h00);
    step();
    hwdata = 32'h1;
    addr(0, 32'h10, 0, HSIZE_WORD, 1, 8'h00);
    step();
    n_total++; if (hexokay0 !== EXCL) $display("FAIL excl_rd_okay got %b exp %b", hexokay0, EXCL); else n_pass++;
    n_total++; if (hrdata0 !== 32'h1) $display("FAIL excl_rd_data got %h exp 1", hrdata0); else n_pass++;
    addr(0, 32'h10, 1, HSIZE_WORD, 1, 8'h00);
    step();
    hwdata = 32'h2;
    n_total++; if (hexokay0 !== EXCL) $display("FAIL excl_wr_okay got %b exp %b", hexokay0, EXCL); else n_pass++;
    addr(0, 32'h10, 0, HSIZE_WORD, 0, 8'h00);
    step();
    n_total++; if (hrdata0 !== 32'h2) $display("FAIL excl_wr_landed got %h exp 2", hrdata0); else n_pass++;
    n_total++; if (hexokay0 !== 1'b0) $display("FAIL excl_normal_rd_okay got %b exp 0", hexokay0); else n_pass++;
    addr(0, 32'h10, 0, HSIZE_WORD, 1, 8'h00);
    step();
    addr(0, 32'h10, 1, HSIZE_WORD, 0, 8'h01);
    step();
    hwdata = 32'h3;
    n_total++; if (hexokay0 !== 1'b0) $display("FAIL excl_m1_wr_okay got %b exp 0", hexokay0); else n_pass++;
    addr(0, 32'h10, 1, HSIZE_WORD, 1, 8'h00);
    step();
    hwdata = 32'h4;
    n_total++; if ({hexokay0, hresp0} !== 2'b00) $display("FAIL excl_lost_wr got %b exp 00", {hexokay0, hresp0}); else n_pass++;
    addr(0, 32'h10, 0, HSIZE_WORD, 0, 8'h00);
    step();
    idle_bus();
    n_total++; if (hrdata0 !== (EXCL ? 32'h3 : 32'h4)) $display("FAIL excl_final_value got %h exp %h", hrdata0, EXCL ? 32'h3 : 32'h4); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    addr(1, 32'h40, 1, HSIZE_WORD, 0, 8'h00);
    hwdata = 32'h0BADBEEF;
    step();
    idle_bus();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (hreadyout3 !== 1'b1) $display("FAIL rstmid_hreadyout got %b exp 1", hreadyout3); else n_pass++;
    n_total++; if (hresp3 !== 1'b0) $display("FAIL rstmid_hresp got %b exp 0", hresp3); else n_pass++;
    n_total++; if (hrdata3 !== 32'h0) $display("FAIL rstmid_hrdata got %h exp 0", hrdata3); else n_pass++;
    n_total++; if (hexokay3 !== 1'b0) $display("FAIL rstmid_hexokay got %b exp 0", hexokay3); else n_pass++;
    step();
    addr(1, 32'h40, 0, HSIZE_WORD, 0, 8'h00);
    step();
    idle_bus();
    n = 0;
    while (!hreadyout3 && n < 20) begin
      n++;
      step();
    end
    n_total++; if (hrdata3 !== 32'hCAFEF00D) $display("FAIL rstmid_word_kept got %h exp CAFEF00D", hrdata3); else n_pass++;
    step();
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_forward();
    test_byte_merge();
    test_wait_states();
    test_error();
    test_exclusive();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
